// File: rtl/ltc2195_frame_avg.sv
// ltc2195_frame_avg
// Downstream stage of the LTC2195 ADC controller. Registers each ADC sample
// pair with its frame word, checks the frame pattern, tracks lock with a small
// FSM and counts frame errors with a saturating counter. While locked it
// boxcar-averages both channels over windows of 2^k samples and emits one
// decimated output pair per window. Configuration arrives on the shared
// command bus in the 16'h33?? page.

module ltc2195_frame_avg #(
    parameter logic [3:0] FR_PATTERN = 4'b1100,
    parameter int         LOCK_RUN   = 16,
    parameter int         MAX_LOG2   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_trig_in,
    input  logic [15:0] cmd_addr_in,
    input  logic [15:0] cmd_data_in,
    input  logic [15:0] adc0_in,
    input  logic [15:0] adc1_in,
    input  logic [3:0]  fr_in,
    output logic [15:0] avg0_out,
    output logic [15:0] avg1_out,
    output logic        avg_valid_out,
    output logic        locked_out,
    output logic [15:0] err_count_out
);

    // Accumulator holds 2^MAX_LOG2 full-scale 16-bit samples without overflow.
    localparam int         ACC_W      = 16 + MAX_LOG2;
    // Window count must be able to represent 2^MAX_LOG2.
    localparam int         CNT_W      = MAX_LOG2 + 1;
    localparam logic [7:0] LOCK_RUN_8 = 8'(LOCK_RUN);
    localparam logic [3:0] MAX_K      = 4'(MAX_LOG2);

    localparam logic [15:0] ADDR_SET_K   = 16'h3300;
    localparam logic [15:0] ADDR_CLR_ERR = 16'h3301;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0]  r_adc0;
    logic [15:0]  r_adc1;
    logic [3:0]   r_fr;
    logic         r_s1_valid;

    lock_state_t  r_state;
    logic [7:0]   r_run;
    logic         r_locked;

    logic [15:0]  r_err;

    logic [3:0]       r_k;
    logic [CNT_W-1:0] r_count;
    logic             r_avg_valid;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic             w_match;
    logic             w_mismatch;
    logic             w_cmd_set_k;
    logic             w_cmd_clr_err;
    logic [3:0]       w_k_new;
    logic             w_accept;
    logic [CNT_W-1:0] w_n_minus1;
    logic             w_last;
    logic             w_win_clear;
    logic [15:0]      w_sample [2];
    logic [15:0]      w_avg    [2];

    // Only the low nibble of the command data carries the k value.
    logic             w_unused_data;
    assign w_unused_data = &{1'b0, cmd_data_in[15:4]};

    // ------------------------------------------------------------------
    // Stage 1: register samples and frame word every cycle
    // ------------------------------------------------------------------
    // The valid flag keeps the sample captured during reset from being
    // judged as a frame once reset is released.
    always_ff @(posedge clk_in) begin
        r_adc0 <= adc0_in;
        r_adc1 <= adc1_in;
        r_fr   <= fr_in;
        if (rst_in) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame check, command decode and window control
    // ------------------------------------------------------------------
    assign w_match       = r_s1_valid && (r_fr == FR_PATTERN);
    assign w_mismatch    = r_s1_valid && (r_fr != FR_PATTERN);

    assign w_cmd_set_k   = cmd_trig_in && (cmd_addr_in == ADDR_SET_K);
    assign w_cmd_clr_err = cmd_trig_in && (cmd_addr_in == ADDR_CLR_ERR);
    assign w_k_new       = (cmd_data_in[3:0] > MAX_K) ? MAX_K : cmd_data_in[3:0];

    // A sample is only averaged when already locked and its frame is good;
    // the frame that completes lock acquisition is therefore never used.
    assign w_accept      = (r_state == ST_LOCKED) && w_match;
    assign w_n_minus1    = (CNT_W'(1) << r_k) - CNT_W'(1);
    assign w_last        = w_accept && (r_count == w_n_minus1);

    // Partial windows are discarded on a k change or on loss of lock.
    assign w_win_clear   = w_cmd_set_k || ((r_state == ST_LOCKED) && w_mismatch);

    assign w_sample[0]   = r_adc0;
    assign w_sample[1]   = r_adc1;

    // ------------------------------------------------------------------
    // Lock FSM: count consecutive good frames, drop out on any bad frame
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ST_UNLOCKED;
            r_run    <= 8'd0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_match) begin
                        if (r_run == LOCK_RUN_8 - 8'd1) begin
                            r_state  <= ST_LOCKED;
                            r_run    <= 8'd0;
                            r_locked <= 1'b1;
                        end else begin
                            r_run <= r_run + 8'd1;
                        end
                    end else if (w_mismatch) begin
                        r_run <= 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_mismatch) begin
                        r_state  <= ST_UNLOCKED;
                        r_run    <= 8'd0;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_UNLOCKED;
                    r_run    <= 8'd0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating frame-error counter; a software clear beats a new error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_err <= 16'd0;
        end else if (w_cmd_clr_err) begin
            r_err <= 16'd0;
        end else if (w_mismatch && (r_err != 16'hFFFF)) begin
            r_err <= r_err + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Decimation exponent, shared window count and output strobe
    // ------------------------------------------------------------------
    // A window that completes in the same cycle as a k write is produced
    // with the old k because the shift uses r_k before it is updated.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_k         <= 4'd0;
            r_count     <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_last;
            if (w_win_clear || w_last) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_cmd_set_k) begin
                r_k <= w_k_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel accumulator and averaged output
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [ACC_W-1:0] r_acc;
            logic        [15:0]      r_avg;
            logic signed [ACC_W-1:0] w_ext;
            logic signed [ACC_W-1:0] w_sum;
            logic        [15:0]      w_avg_next;

            assign w_ext      = {{(ACC_W-16){w_sample[gi][15]}}, w_sample[gi]};
            assign w_sum      = r_acc + w_ext;
            // Arithmetic shift floors toward minus infinity.
            assign w_avg_next = 16'(w_sum >>> r_k);

            // Accumulate accepted samples; publish and restart on the last one.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_acc <= '0;
                    r_avg <= 16'd0;
                end else begin
                    if (w_last) begin
                        r_avg <= w_avg_next;
                    end
                    if (w_win_clear || w_last) begin
                        r_acc <= '0;
                    end else if (w_accept) begin
                        r_acc <= w_sum;
                    end
                end
            end

            assign w_avg[gi] = r_avg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avg0_out      = w_avg[0];
    assign avg1_out      = w_avg[1];
    assign avg_valid_out = r_avg_valid;
    assign locked_out    = r_locked;
    assign err_count_out = r_err;

endmodule

// File: tb/tb_ltc2195_frame_avg.sv
// Testbench for ltc2195_frame_avg: directed table of vectors with
// hand-computed outputs, plus loops for lock, clamp, reset and saturation.

module tb_ltc2195_frame_avg;

    localparam logic [3:0] GOOD = 4'b1100;
    localparam logic [3:0] BAD  = 4'b0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_trig_in;
    logic [15:0] cmd_addr_in;
    logic [15:0] cmd_data_in;
    logic [15:0] adc0_in;
    logic [15:0] adc1_in;
    logic [3:0]  fr_in;
    logic [15:0] avg0_out;
    logic [15:0] avg1_out;
    logic        avg_valid_out;
    logic        locked_out;
    logic [15:0] err_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    ltc2195_frame_avg dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cmd_trig_in   (cmd_trig_in),
        .cmd_addr_in   (cmd_addr_in),
        .cmd_data_in   (cmd_data_in),
        .adc0_in       (adc0_in),
        .adc1_in       (adc1_in),
        .fr_in         (fr_in),
        .avg0_out      (avg0_out),
        .avg1_out      (avg1_out),
        .avg_valid_out (avg_valid_out),
        .locked_out    (locked_out),
        .err_count_out (err_count_out)
    );

    typedef struct {
        logic [15:0] a0;
        logic [15:0] a1;
        logic [3:0]  fr;
        logic        trig;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ev;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        el;
        logic [15:0] ee;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input int a0, input int a1, input logic [3:0] fr,
                         input logic trig, input logic [15:0] addr, input logic [15:0] data);
        adc0_in     = 16'(a0);
        adc1_in     = 16'(a1);
        fr_in       = fr;
        cmd_trig_in = trig;
        cmd_addr_in = addr;
        cmd_data_in = data;
    endtask

    // Advance one clock and settle past the edge before sampling outputs.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected values are the outputs observed right after this vector's edge.
    task automatic add(input int a0, input int a1, input logic [3:0] fr,
                       input logic trig, input logic [15:0] addr, input logic [15:0] data,
                       input logic ev, input int e0, input int e1, input logic el, input int ee);
        vec_t v;
        v.a0 = 16'(a0); v.a1 = 16'(a1); v.fr = fr;
        v.trig = trig; v.addr = addr; v.data = data;
        v.ev = ev; v.e0 = 16'(e0); v.e1 = 16'(e1); v.el = el; v.ee = 16'(ee);
        tbl.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [15:0] e0,
                             input logic [15:0] e1, input logic el, input logic [15:0] ee);
        check({tag, " valid"},  {15'd0, avg_valid_out}, {15'd0, ev});
        check({tag, " avg0"},   avg0_out, e0);
        check({tag, " avg1"},   avg1_out, e1);
        check({tag, " locked"}, {15'd0, locked_out}, {15'd0, el});
        check({tag, " err"},    err_count_out, ee);
    endtask

    initial begin
        int nvalid;

        // ---------------- table fill ----------------
        // k=0 passthrough ramp; first entry is the frame after the 16th lock frame
        add(-5,  32767, GOOD, 0, 0, 0, 0,  0,      0,      1, 0);
        add(-4,  32766, GOOD, 0, 0, 0, 1, -5,      32767,  1, 0);
        add(-3,  1,     GOOD, 0, 0, 0, 1, -4,      32766,  1, 0);
        add(-2,  0,     GOOD, 0, 0, 0, 1, -3,      1,      1, 0);
        add(-1,  -1,    GOOD, 0, 0, 0, 1, -2,      0,      1, 0);
        add(0,   -2,    GOOD, 0, 0, 0, 1, -1,      -1,     1, 0);
        add(1,   -32767,GOOD, 0, 0, 0, 1,  0,      -2,     1, 0);
        add(2,   -32768,GOOD, 0, 0, 0, 1,  1,      -32767, 1, 0);
        add(3,   100,   GOOD, 0, 0, 0, 1,  2,      -32768, 1, 0);
        add(4,   -100,  GOOD, 0, 0, 0, 1,  3,      100,    1, 0);
        add(5,   -32768,GOOD, 0, 0, 0, 1,  4,      -100,   1, 0);
        // k=2 written while the last k=0 window completes; window 1,2,3,4
        add(1,   10,    GOOD, 1, 16'h3300, 16'd2, 1, 5, -32768, 1, 0);
        add(2,   20,    GOOD, 0, 0, 0, 0,  5,      -32768, 1, 0);
        add(3,   30,    GOOD, 0, 0, 0, 0,  5,      -32768, 1, 0);
        add(4,   40,    GOOD, 0, 0, 0, 0,  5,      -32768, 1, 0);
        // window -1,-1,-1,-2 floors to -2
        add(-1,  -1,    GOOD, 0, 0, 0, 1,  2,      25,     1, 0);
        add(-1,  -1,    GOOD, 0, 0, 0, 0,  2,      25,     1, 0);
        add(-1,  -1,    GOOD, 0, 0, 0, 0,  2,      25,     1, 0);
        add(-2,  -2,    GOOD, 0, 0, 0, 0,  2,      25,     1, 0);
        // k=3 written as the k=2 window completes; 5 samples then a bad frame
        add(7,   7,     GOOD, 1, 16'h3300, 16'd3, 1, -2, -2, 1, 0);
        for (int i = 0; i < 4; i++) add(7, 7, GOOD, 0, 0, 0, 0, -2, -2, 1, 0);
        add(9,   9,     BAD,  0, 0, 0, 0, -2, -2, 1, 0);
        add(9,   9,     GOOD, 0, 0, 0, 0, -2, -2, 0, 1);
        // controller-page address must not clear the error count
        add(9,   9,     BAD,  1, 16'h3201, 16'd0, 0, -2, -2, 0, 1);
        // clear lands on the same edge the bad frame is judged: count ends at 0
        add(100, 100,   GOOD, 1, 16'h3301, 16'd0, 0, -2, -2, 0, 0);
        // remaining 15 lock frames, then 8 samples; lock frame is not averaged
        for (int i = 0; i < 15; i++) add(100, 100, GOOD, 0, 0, 0, 0, -2, -2, 0, 0);
        for (int i = 1; i <= 8; i++) add(i, -3, GOOD, 0, 0, 0, 0, -2, -2, 1, 0);
        add(0,   0,     GOOD, 0, 0, 0, 1,  4,      -3,     1, 0);
        add(0,   0,     GOOD, 0, 0, 0, 0,  4,      -3,     1, 0);

        // ---------------- reset state ----------------
        rst_in = 1'b1;
        drive(100, 100, GOOD, 0, 0, 0);
        step();
        step();
        check_all("reset", 0, 16'd0, 16'd0, 0, 16'd0);
        rst_in = 1'b0;

        // ---------------- lock acquisition ----------------
        nvalid = 0;
        for (int j = 1; j <= 16; j++) begin
            drive(100, 100, GOOD, 0, 0, 0);
            step();
            if (avg_valid_out) nvalid++;
            check($sformatf("lock frame %0d locked", j), {15'd0, locked_out}, 16'd0);
        end
        check("no valid before lock", 16'(nvalid), 16'd0);
        check("lock err", err_count_out, 16'd0);

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            drive(int'($signed(tbl[i].a0)), int'($signed(tbl[i].a1)), tbl[i].fr,
                  tbl[i].trig, tbl[i].addr, tbl[i].data);
            step();
            check_all($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].e0, tbl[i].e1, tbl[i].el, tbl[i].ee);
        end

        // ---------------- clamp: k=15 acts as k=8 ----------------
        nvalid = 0;
        for (int i = 0; i < 256; i++) begin
            drive(-32768, 32767, GOOD, (i == 0), 16'h3300, 16'd15);
            step();
            if (avg_valid_out) nvalid++;
        end
        check("clamp no early valid", 16'(nvalid), 16'd0);
        drive(0, 0, GOOD, 0, 0, 0);
        step();
        check("clamp valid", {15'd0, avg_valid_out}, 16'd1);
        check("clamp avg0", avg0_out, 16'h8000);
        check("clamp avg1", avg1_out, 16'h7FFF);
        step();
        check("clamp pulse width", {15'd0, avg_valid_out}, 16'd0);

        // ---------------- reset mid-window ----------------
        drive(55, 55, GOOD, 0, 0, 0);
        step();
        rst_in = 1'b1;
        step();
        check_all("mid reset", 0, 16'd0, 16'd0, 0, 16'd0);
        rst_in = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            drive(100, 100, GOOD, 0, 0, 0);
            step();
        end
        drive(1234, -1234, GOOD, 0, 0, 0);
        step();
        check("relock locked", {15'd0, locked_out}, 16'd1);
        drive(0, 0, GOOD, 0, 0, 0);
        step();
        check("relock k0 valid", {15'd0, avg_valid_out}, 16'd1);
        check("relock k0 avg0", avg0_out, 16'h04D2);
        check("relock k0 avg1", avg1_out, 16'hFB2E);

        // ---------------- error counter saturation ----------------
        nvalid = 0;
        for (int i = 0; i < 70000; i++) begin
            drive(0, 0, BAD, 0, 0, 0);
            step();
            if (i > 1 && avg_valid_out) nvalid++;
        end
        check("sat valid while unlocked", 16'(nvalid), 16'd0);
        check("sat locked", {15'd0, locked_out}, 16'd0);
        check("sat err", err_count_out, 16'hFFFF);
        drive(0, 0, GOOD, 1, 16'h3301, 16'd0);
        step();
        check("sat clear", err_count_out, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ltc2195_frame_avg.md
# ltc2195_frame_avg

Downstream stage of the LTC2195 ADC controller. It takes the parallel ADC0/ADC1 samples and 4-bit frame word that the controller produces once per `clk_in` cycle. It validates the frame pattern, maintains a lock state and a saturating frame-error counter, and outputs boxcar-averaged, power-of-two-decimated samples of both channels. Configuration arrives on the same command bus as the controller, in the `16'h33??` address page.

## Interface
Parameters:
- `FR_PATTERN`, `4'b1100`: expected frame word on `fr_in` for a correctly aligned sample.
- `LOCK_RUN`, `16`: consecutive matching frames required to enter LOCKED (range 1..255).
- `MAX_LOG2`, `8`: maximum decimation exponent k. Accumulator width is `16+MAX_LOG2`.

Ports:
- `clk_in`, in, 1: sample clock; one ADC sample pair per cycle.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `cmd_trig_in`, in, 1: one-cycle command strobe.
- `cmd_addr_in`, in, 16: command address.
- `cmd_data_in`, in, 16: command data.
- `adc0_in`, in, 16 signed: ADC channel 0 sample (two's complement).
- `adc1_in`, in, 16 signed: ADC channel 1 sample.
- `fr_in`, in, 4: frame word accompanying the samples.
- `avg0_out`, out, 16 signed: channel 0 average.
- `avg1_out`, out, 16 signed: channel 1 average.
- `avg_valid_out`, out, 1: one-cycle pulse when `avg*_out` update.
- `locked_out`, out, 1: high in LOCKED state.
- `err_count_out`, out, 16: saturating count of mismatching frames.

## Operation
- **Input stage:** `adc0_in`, `adc1_in` and `fr_in` are registered every cycle (stage 1). All checks use the stage-1 copies. A frame "matches" when stage-1 `fr` equals `FR_PATTERN`.
- **Lock FSM:**
  - States UNLOCKED and LOCKED, plus an 8-bit run counter.
  - UNLOCKED: a match increments run; a mismatch clears run. When run reaches `LOCK_RUN`, go to LOCKED and clear run.
  - LOCKED: any mismatch goes to UNLOCKED, clears run and clears the accumulator and window count.
- **Error counter:** increments on every mismatching stage-1 frame, in either state. It holds at `16'hFFFF`.
- **Accumulation rule:** the stage-1 sample pair is accumulated only when the FSM is LOCKED in that cycle and the frame matches. The frame that causes the UNLOCKED→LOCKED transition is not accumulated.
- **Averager:**
  - N = 2^k. Per channel, a 24-bit signed accumulator and a 9-bit window count.
  - On the Nth accepted sample, output `(acc + sample) >>> k` (arithmetic shift, truncation toward −∞) as the low 16 bits and pulse `avg_valid_out`. Then restart the accumulator at 0 with count 0.
  - No saturation is needed: 2^8 × 16-bit fits in 24 bits.
- **Commands**, accepted in the cycle `cmd_trig_in`=1:
  - `16'h3300`: k ← `cmd_data_in[3:0]`, clamped to `MAX_LOG2` if larger. Clears the accumulator and window count.
  - `16'h3301`: clears `err_count_out` (data ignored).
  - All other addresses are ignored, including `16'h31??` and `16'h32??`, which belong to the ADC controller.
- **Simultaneous events:**
  - An error clear in the same cycle as a mismatch leaves the count at 0 (clear wins).
  - A k write in the same cycle as a window completion: the completing window's output is still produced using the old k, then the new k takes effect.
- **Reset values:** `avg0_out`=`avg1_out`=0, `avg_valid_out`=0, `locked_out`=0, `err_count_out`=0, k=0, FSM UNLOCKED, run=0, accumulators and window count 0. Reset mid-window discards the partial window.

## Timing
- Latency from a sample on the inputs to its effect: stage 1 at edge t, then output or state registers at edge t+1.
  - `avg_valid_out` is high in the cycle after edge t+1 for a window whose last sample was presented before edge t.
  - `locked_out` and `err_count_out` follow the same two-edge latency.
- With k=0 and lock held, `avg_valid_out` is high every cycle and `avg*_out` equals the input delayed by 2 cycles.
- `avg_valid_out` is never asserted while `locked_out`=0, and is never high for more than one cycle when k≥1.
- A command takes effect on the edge after the `cmd_trig_in` cycle. No handshake or ready signal; back-to-back commands are accepted every cycle.

## Test plan
- **Reset and lock acquisition:** apply reset, then 16 matching frames → `locked_out` rises 2 cycles after the 16th frame; `err_count_out`=0; no `avg_valid_out` before lock.
- **k=0 passthrough:** while locked, ramp `adc0_in` -5..5 and `adc1_in` 32767..-32768 → `avg*_out` equals the inputs delayed 2 cycles, with `avg_valid_out` high continuously.
- **k=2 averaging:**
  - Write `16'h3300`/`2`, then samples 1,2,3,4 → `avg0_out`=2, one valid pulse per 4 samples.
  - Samples -1,-1,-1,-2 → -2 (floor).
- **Clamp and limit:** write k=15 → behaves as k=8; 256 samples of -32768 → `avg0_out`=-32768 with no overflow.
- **Frame error mid-window:**
  - Locked, k=3: 5 samples, then one bad frame → `locked_out` falls, `err_count_out`=1, partial window discarded; the next output requires 16 good frames plus 8 samples.
  - Write `16'h3301` coincident with a bad frame → count 0.
- **Saturation and reset mid-operation:**
  - Force 70000 bad frames → `err_count_out`=`16'hFFFF`.
  - Assert `rst_in` for one cycle mid-window → all outputs return to reset values on the next edge.
